// File: rtl/ro_pkg.sv
// Shared constants, the slot-owner helper and the default entry layout for the readout capture stage.
// RO_CAPTURE_TSTAMP_EN adds a slot timestamp field to each queued entry.
package ro_pkg;

   localparam int N_CH_DEF = 19;
   localparam int CHAN_W   = $clog2(N_CH_DEF);

   typedef struct packed {
      logic [CHAN_W-1:0]   chan;
      logic                eve;
      logic                pol;
`ifdef RO_CAPTURE_TSTAMP_EN
      logic [N_CH_DEF-1:0] tstamp;
`endif
   } ro_entry_t;

   // Lowest set bit among the low n bits; the all-zero wrap slot belongs to channel n-1.
   function automatic int ctz(input logic [31:0] v, input int n);
      int   r;
      logic found;
      r     = n - 1;
      found = 1'b0;
      for (int i = 0; i < 32; i++) begin
         if (!found && (i < n) && v[i]) begin
            r     = i;
            found = 1'b1;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/ro_fifo.sv
// Generic synchronous first-word-fall-through FIFO; a push while full is ignored unless a pop frees
// the head slot in the same cycle. The head reads as zero while empty.
module ro_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk_master,
   input  logic             rstb,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   output logic             full,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             wr_en, rd_en;

   always_comb begin
      empty    = (wr_ptr_q == rd_ptr_q);
      full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      rd_en    = pop & ~empty;
      wr_en    = push & (~full | rd_en);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      mem_d    = mem_q;
      if (wr_en) begin
         mem_d[wr_ptr_q[AW-1:0]] = push_data;
         wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
      end
      if (rd_en) begin
         rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end
      pop_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
   end

   always_ff @(posedge clk_master or negedge rstb) begin
      if (!rstb) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk_master) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/ro_capture.sv
// Capture stage for the shared readout lines: tracks the slot owner, samples on the negedge and queues
// non-empty samples. Define RO_CAPTURE_TSTAMP_EN to store and expose the slot count of each entry.
module ro_capture
   import ro_pkg::*;
#(
   parameter int N_CH       = N_CH_DEF,
   parameter int FIFO_DEPTH = 8,
   parameter int DROP_W     = 8
) (
   input  logic                    clk_master,
   input  logic                    rstb,
   input  logic                    ro_eve,
   input  logic                    ro_pol_eve,
   input  logic                    out_ready,
   output logic                    out_valid,
   output logic [$clog2(N_CH)-1:0] out_chan,
   output logic                    out_eve,
   output logic                    out_pol,
`ifdef RO_CAPTURE_TSTAMP_EN
   output logic [N_CH-1:0]         out_tstamp,
`endif
   output logic [DROP_W-1:0]       drop_cnt,
   output logic                    overflow
);

   localparam int CW = $clog2(N_CH);

   typedef struct packed {
      logic [CW-1:0]   chan;
      logic            eve;
      logic            pol;
`ifdef RO_CAPTURE_TSTAMP_EN
      logic [N_CH-1:0] tstamp;
`endif
   } entry_t;

   localparam int ENTRY_W = $bits(entry_t);

   logic [N_CH-1:0]   slot_q, slot_d;
   logic [CW-1:0]     chan_now;
   logic              samp_vld_q, samp_vld_d;
   logic              cap_eve_q, cap_eve_d;
   logic              cap_pol_q, cap_pol_d;
   logic [CW-1:0]     cap_chan_q, cap_chan_d;
`ifdef RO_CAPTURE_TSTAMP_EN
   logic [N_CH-1:0]   cap_slot_q, cap_slot_d;
`endif
   logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
   logic              overflow_q, overflow_d;
   logic              push, pop, drop;
   logic              fifo_full, fifo_empty;
   entry_t            push_ent, head_ent;

   always_comb begin
      slot_d     = slot_q + N_CH'(1);
      chan_now   = CW'(ctz(32'(slot_q), N_CH));
      cap_eve_d  = ro_eve;
      cap_pol_d  = ro_pol_eve;
      cap_chan_d = chan_now;
`ifdef RO_CAPTURE_TSTAMP_EN
      cap_slot_d = slot_q;
`endif
      samp_vld_d = 1'b1;
   end

   always_ff @(posedge clk_master or negedge rstb) begin
      if (!rstb) begin
         slot_q <= '0;
      end else begin
         slot_q <= slot_d;
      end
   end

   // Lines are only driven in the high phase, so the sample is taken on the falling edge.
   always_ff @(negedge clk_master or negedge rstb) begin
      if (!rstb) begin
         samp_vld_q <= 1'b0;
         cap_eve_q  <= 1'b0;
         cap_pol_q  <= 1'b0;
         cap_chan_q <= '0;
`ifdef RO_CAPTURE_TSTAMP_EN
         cap_slot_q <= '0;
`endif
      end else begin
         samp_vld_q <= samp_vld_d;
         cap_eve_q  <= cap_eve_d;
         cap_pol_q  <= cap_pol_d;
         cap_chan_q <= cap_chan_d;
`ifdef RO_CAPTURE_TSTAMP_EN
         cap_slot_q <= cap_slot_d;
`endif
      end
   end

   always_comb begin
      push          = samp_vld_q & (cap_eve_q | cap_pol_q);
      pop           = ~fifo_empty & out_ready;
      drop          = push & fifo_full & ~pop;
      push_ent      = '0;
      push_ent.chan = cap_chan_q;
      push_ent.eve  = cap_eve_q;
      push_ent.pol  = cap_pol_q;
`ifdef RO_CAPTURE_TSTAMP_EN
      push_ent.tstamp = cap_slot_q;
`endif
      drop_cnt_d = drop_cnt_q;
      if (drop && (drop_cnt_q != '1)) begin
         drop_cnt_d = drop_cnt_q + DROP_W'(1);
      end
      overflow_d = overflow_q | drop;
   end

   always_ff @(posedge clk_master or negedge rstb) begin
      if (!rstb) begin
         drop_cnt_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
         overflow_q <= overflow_d;
      end
   end

   ro_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_master (clk_master),
      .rstb       (rstb),
      .push       (push),
      .push_data  (push_ent),
      .full       (fifo_full),
      .pop        (pop),
      .pop_data   (head_ent),
      .empty      (fifo_empty)
   );

   always_comb begin
      out_valid = ~fifo_empty;
      out_chan  = head_ent.chan;
      out_eve   = head_ent.eve;
      out_pol   = head_ent.pol;
`ifdef RO_CAPTURE_TSTAMP_EN
      out_tstamp = head_ent.tstamp;
`endif
      drop_cnt  = drop_cnt_q;
      overflow  = overflow_q;
   end

endmodule
